// File: rtl/tt_um_weights_pkg.sv
// Shared constants and types for the ternary weight unload path.
package tt_um_weights_pkg;

  localparam int MAX_IN_LEN_DEF  = 16;
  localparam int MAX_OUT_LEN_DEF = 8;

  localparam logic PHASE_MSB = 1'b0;
  localparam logic PHASE_LSB = 1'b1;

  // ui_param field bounds
  localparam int ROW_HI = 6;
  localparam int ROW_LO = 3;
  localparam int COL_HI = 2;
  localparam int COL_LO = 0;
  localparam int NROW_W = ROW_HI - ROW_LO + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSB  = 2'd1,
    LSB  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/tt_um_unload_if.sv
// Output word stream of the weight unloader: valid/ready with phase and last tags.
interface tt_um_unload_if #(
  parameter int MAX_IN_LEN = 16
);

  logic [MAX_IN_LEN-1:0] uo_output;
  logic                  uo_valid;
  logic                  uo_phase;
  logic                  uo_last;
  logic                  ui_ready;

  modport master (
    output uo_output,
    output uo_valid,
    output uo_phase,
    output uo_last,
    input  ui_ready
  );

  modport slave (
    input  uo_output,
    input  uo_valid,
    input  uo_phase,
    input  uo_last,
    output ui_ready
  );

endinterface

// File: rtl/tt_um_weight_col_mux.sv
// Selects one column / one bit-plane of the packed ternary weight array and
// masks rows above the last active row index.
module tt_um_weight_col_mux
  import tt_um_weights_pkg::*;
#(
  parameter int MAX_IN_LEN  = MAX_IN_LEN_DEF,
  parameter int MAX_OUT_LEN = MAX_OUT_LEN_DEF
) (
  input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] snap,
  input  logic [((MAX_OUT_LEN > 1) ? $clog2(MAX_OUT_LEN) : 1)-1:0] col,
  input  logic                                phase,
  input  logic [NROW_W-1:0]                   nrow,
  output logic [MAX_IN_LEN-1:0]               word
);

  localparam int          W_BITS = 2 * MAX_IN_LEN * MAX_OUT_LEN;
  localparam int          IDX_W  = $clog2(W_BITS);
  localparam int unsigned N_COL  = MAX_OUT_LEN;

  logic [IDX_W-1:0] idx;

  // Bit r is the selected plane of w[r*MAX_OUT_LEN+col]; MSB plane is the upper bit of each pair.
  always_comb begin
    word = '0;
    idx  = '0;
    for (int unsigned r = 0; r < MAX_IN_LEN; r++) begin
      if ((r <= 32'(nrow)) && (32'(col) < N_COL)) begin
        idx     = IDX_W'(2 * (r * N_COL + 32'(col)) + 32'(phase == PHASE_MSB));
        word[r] = snap[idx];
      end
    end
  end

endmodule

// File: rtl/tt_um_unload.sv
// Weight readback transmitter: snapshots the ternary weight array on start and
// streams it column by column as an MSB-plane word followed by an LSB-plane word.
module tt_um_unload
  import tt_um_weights_pkg::*;
#(
  parameter int MAX_IN_LEN  = MAX_IN_LEN_DEF,
  parameter int MAX_OUT_LEN = MAX_OUT_LEN_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                ena,
  input  logic                                ui_start,
  input  logic [6:0]                          ui_param,
  input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
  tt_um_unload_if.master                      out_if,
  output logic                                uo_busy,
  output logic                                uo_done
);

  localparam int COL_W  = (MAX_OUT_LEN > 1) ? $clog2(MAX_OUT_LEN) : 1;
  localparam int W_BITS = 2 * MAX_IN_LEN * MAX_OUT_LEN;

  state_t                  state;
  logic [W_BITS-1:0]       snap;
  logic [NROW_W-1:0]       nrow;
  logic [COL_W-1:0]        ncol;
  logic [COL_W-1:0]        col;
  logic [MAX_IN_LEN-1:0]   out_word;
  logic                    out_valid;
  logic                    out_phase;
  logic                    out_last;
  logic                    busy_q;
  logic                    done_q;

  logic [COL_W-1:0]        ncol_in;
  logic [W_BITS-1:0]       m_snap;
  logic [NROW_W-1:0]       m_nrow;
  logic [COL_W-1:0]        m_col;
  logic                    m_phase;
  logic [MAX_IN_LEN-1:0]   m_word;

  // Clamp the requested last column to the physical column count.
  always_comb begin
    if (32'(ui_param[COL_HI:COL_LO]) > 32'(MAX_OUT_LEN - 1))
      ncol_in = COL_W'(MAX_OUT_LEN - 1);
    else
      ncol_in = COL_W'(ui_param[COL_HI:COL_LO]);
  end

  // Mux operands describe the word of the state about to be entered, so the output
  // register can load it on the entry edge; from IDLE the snapshot is not yet
  // registered, hence the raw inputs are used.
  always_comb begin
    m_snap  = snap;
    m_nrow  = nrow;
    m_col   = col;
    m_phase = PHASE_MSB;
    case (state)
      IDLE: begin
        m_snap  = ui_weights;
        m_nrow  = ui_param[ROW_HI:ROW_LO];
        m_col   = '0;
        m_phase = PHASE_MSB;
      end
      MSB: begin
        m_col   = col;
        m_phase = PHASE_LSB;
      end
      LSB: begin
        m_col   = col + COL_W'(1);
        m_phase = PHASE_MSB;
      end
      default: ;
    endcase
  end

  tt_um_weight_col_mux #(
    .MAX_IN_LEN  (MAX_IN_LEN),
    .MAX_OUT_LEN (MAX_OUT_LEN)
  ) u_col_mux (
    .snap  (m_snap),
    .col   (m_col),
    .phase (m_phase),
    .nrow  (m_nrow),
    .word  (m_word)
  );

  // Stream FSM with snapshot, column counter and registered outputs; ena low freezes all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      snap      <= '0;
      nrow      <= '0;
      ncol      <= '0;
      col       <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      out_phase <= PHASE_MSB;
      out_last  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (ui_start) begin
            snap      <= ui_weights;
            nrow      <= ui_param[ROW_HI:ROW_LO];
            ncol      <= ncol_in;
            col       <= '0;
            out_word  <= m_word;
            out_valid <= 1'b1;
            out_phase <= PHASE_MSB;
            out_last  <= 1'b0;
            busy_q    <= 1'b1;
            state     <= MSB;
          end
        end
        MSB: begin
          if (out_if.ui_ready) begin
            out_word  <= m_word;
            out_phase <= PHASE_LSB;
            out_last  <= (col == ncol);
            state     <= LSB;
          end
        end
        LSB: begin
          if (out_if.ui_ready) begin
            if (col == ncol) begin
              out_word  <= '0;
              out_valid <= 1'b0;
              out_phase <= PHASE_MSB;
              out_last  <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state     <= FIN;
            end else begin
              col       <= col + COL_W'(1);
              out_word  <= m_word;
              out_phase <= PHASE_MSB;
              out_last  <= 1'b0;
              state     <= MSB;
            end
          end
        end
        FIN: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_if.uo_output = out_word;
  assign out_if.uo_valid  = out_valid;
  assign out_if.uo_phase  = out_phase;
  assign out_if.uo_last   = out_last;
  assign uo_busy          = busy_q;
  assign uo_done          = done_q;

endmodule

// File: tb/tb_tt_um_unload.sv
// Directed bench for the weight unloader: table-driven uniform-fill streams,
// a hand-computed patterned stream, reset/backpressure/freeze sequences and a loopback into a loader model.
module tb_tt_um_unload;

  localparam int NI = 16;
  localparam int NO = 8;
  localparam int WB = 2 * NI * NO;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          ui_start;
  logic [6:0]    ui_param;
  logic [WB-1:0] ui_weights;
  logic          uo_busy;
  logic          uo_done;

  int checks = 0;
  int errors = 0;

  tt_um_unload_if #(.MAX_IN_LEN(NI)) bus ();

  tt_um_unload #(
    .MAX_IN_LEN  (NI),
    .MAX_OUT_LEN (NO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .ui_start   (ui_start),
    .ui_param   (ui_param),
    .ui_weights (ui_weights),
    .out_if     (bus.master),
    .uo_busy    (uo_busy),
    .uo_done    (uo_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [6:0]  param;
    logic [1:0]  fill;
    int unsigned nwords;
    logic [15:0] msb;
    logic [15:0] lsb;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] exp_w [16];
  logic [15:0] pat_m [3];
  logic [15:0] pat_l [3];
  logic [WB-1:0] pat;
  logic [WB-1:0] src;
  logic [1:0]    ld [128];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [WB-1:0] rand_bits();
    logic [WB-1:0] w;
    for (int j = 0; j < WB / 32; j++) w[j*32 +: 32] = $urandom();
    return w;
  endfunction

  // Pulse start with the given image, then scramble the inputs to prove the snapshot holds.
  task automatic start(input logic [6:0] p, input logic [WB-1:0] w);
    ui_param   = p;
    ui_weights = w;
    ui_start   = 1'b1;
    @(posedge clk); #1;
    ui_start   = 1'b0;
    ui_weights = rand_bits();
    ui_param   = 7'($urandom());
  endtask

  task automatic check_held(input string tag, input int unsigned i, input int unsigned n);
    chk({tag, " hold valid"}, 32'(bus.uo_valid), 1);
    chk({tag, " hold word"},  32'(bus.uo_output), 32'(exp_w[i]));
    chk({tag, " hold phase"}, 32'(bus.uo_phase), i % 2);
    chk({tag, " hold last"},  32'(bus.uo_last), 32'(i == n - 1));
    chk({tag, " hold busy"},  32'(uo_busy), 1);
    chk({tag, " hold done"},  32'(uo_done), 0);
  endtask

  // Called one cycle after the start edge; expects exp_w[0..n-1] back to back unless stalled.
  task automatic run_stream(input int unsigned n, input int stall_idx, input int unsigned stall_len,
                            input bit stall_ena, input bit noise, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      chk({tag, " valid"}, 32'(bus.uo_valid), 1);
      chk({tag, " word"},  32'(bus.uo_output), 32'(exp_w[i]));
      chk({tag, " phase"}, 32'(bus.uo_phase), i % 2);
      chk({tag, " last"},  32'(bus.uo_last), 32'(i == n - 1));
      chk({tag, " busy"},  32'(uo_busy), 1);
      if (int'(i) == stall_idx) begin
        if (stall_ena) ena = 1'b0; else bus.ui_ready = 1'b0;
        for (int unsigned k = 0; k < stall_len; k++) begin
          if (noise) begin
            ui_start   = 1'b1;
            ui_weights = rand_bits();
          end
          @(posedge clk); #1;
          ui_start = 1'b0;
          check_held(tag, i, n);
        end
        ena          = 1'b1;
        bus.ui_ready = 1'b1;
      end
      if (noise) begin
        ui_start   = 1'b1;
        ui_weights = rand_bits();
        ui_param   = 7'($urandom());
      end
      @(posedge clk); #1;
      ui_start = 1'b0;
    end
    chk({tag, " done pulse"}, 32'(uo_done), 1);
    chk({tag, " fin valid"},  32'(bus.uo_valid), 0);
    chk({tag, " fin busy"},   32'(uo_busy), 0);
    @(posedge clk); #1;
    chk({tag, " done cleared"}, 32'(uo_done), 0);
    chk({tag, " idle valid"},   32'(bus.uo_valid), 0);
  endtask

  task automatic fill_pattern_exp();
    for (int i = 0; i < 16; i++) exp_w[i] = (i % 2 == 1) ? pat_l[(i / 2) % 3] : pat_m[(i / 2) % 3];
  endtask

  initial begin
    // {param, fill, words, msb word, lsb word}
    vecs[0] = '{7'h00, 2'b11,  2, 16'h0001, 16'h0001};
    vecs[1] = '{7'h19, 2'b11,  4, 16'h000F, 16'h000F};
    vecs[2] = '{7'h7F, 2'b01, 16, 16'h0000, 16'hFFFF};
    vecs[3] = '{7'h3A, 2'b11,  6, 16'h00FF, 16'h00FF};
    vecs[4] = '{7'h78, 2'b01,  2, 16'h0000, 16'hFFFF};
    vecs[5] = '{7'h07, 2'b11, 16, 16'h0001, 16'h0001};
    vecs[6] = '{7'h2C, 2'b00, 10, 16'h0000, 16'h0000};
    vecs[7] = '{7'h4D, 2'b01, 12, 16'h0000, 16'h03FF};

    // w[g] = g%3 -> column c repeats with period 3 (hand-derived planes)
    pat_m[0] = 16'h2492; pat_l[0] = 16'h6DB6;
    pat_m[1] = 16'h4924; pat_l[1] = 16'hDB6D;
    pat_m[2] = 16'h9249; pat_l[2] = 16'hB6DB;
    for (int g = 0; g < 128; g++) begin
      case (g % 3)
        0:       pat[2*g +: 2] = 2'b00;
        1:       pat[2*g +: 2] = 2'b01;
        default: pat[2*g +: 2] = 2'b11;
      endcase
    end

    rst_n        = 1'b0;
    ena          = 1'b1;
    ui_start     = 1'b0;
    ui_param     = '0;
    ui_weights   = '0;
    bus.ui_ready = 1'b1;
    #1;
    chk("reset word",  32'(bus.uo_output), 0);
    chk("reset valid", 32'(bus.uo_valid), 0);
    chk("reset phase", 32'(bus.uo_phase), 0);
    chk("reset last",  32'(bus.uo_last), 0);
    chk("reset busy",  32'(uo_busy), 0);
    chk("reset done",  32'(uo_done), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // start with ena low is not accepted
    ena = 1'b0; ui_start = 1'b1; ui_param = 7'h7F; ui_weights = pat;
    @(posedge clk); #1;
    ena = 1'b1; ui_start = 1'b0;
    chk("ena-low start valid", 32'(bus.uo_valid), 0);
    chk("ena-low start busy",  32'(uo_busy), 0);
    @(posedge clk); #1;
    chk("ena-low start stays idle", 32'(bus.uo_valid), 0);

    // uniform-fill table
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 16; i++) exp_w[i] = (i % 2 == 1) ? vecs[v].lsb : vecs[v].msb;
      start(vecs[v].param, {128{vecs[v].fill}});
      run_stream(vecs[v].nwords, -1, 0, 1'b0, 1'b0, $sformatf("tbl%0d", v));
    end

    // reset mid-stream after three transfers
    fill_pattern_exp();
    start(7'h7F, pat);
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
    chk("pre-reset word", 32'(bus.uo_output), 32'(16'hDB6D));
    #2 rst_n = 1'b0;
    #1;
    chk("async reset word",  32'(bus.uo_output), 0);
    chk("async reset valid", 32'(bus.uo_valid), 0);
    chk("async reset phase", 32'(bus.uo_phase), 0);
    chk("async reset last",  32'(bus.uo_last), 0);
    chk("async reset busy",  32'(uo_busy), 0);
    chk("async reset done",  32'(uo_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("no done after abort", 32'(uo_done), 0);
    end

    // full patterned stream from column 0
    start(7'h7F, pat);
    run_stream(16, -1, 0, 1'b0, 1'b0, "full");

    // backpressure on MSB word of column 2
    start(7'h7F, pat);
    run_stream(16, 4, 5, 1'b0, 1'b0, "bp");

    // ena freeze mid-stream plus ignored start pulses and input churn
    start(7'h7F, pat);
    run_stream(16, 5, 4, 1'b1, 1'b1, "frz");

    // loopback into a loader model with random ready
    for (int g = 0; g < 128; g++) begin
      case ($urandom_range(0, 2))
        0:       src[2*g +: 2] = 2'b00;
        1:       src[2*g +: 2] = 2'b01;
        default: src[2*g +: 2] = 2'b11;
      endcase
      ld[g] = 2'b00;
    end
    begin
      int unsigned nw;
      bit fin;
      nw  = 0;
      fin = 1'b0;
      start(7'h5B, src);
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
        if (uo_done) begin
          fin = 1'b1;
        end else begin
          bus.ui_ready = ($urandom_range(0, 3) != 0);
          if (bus.uo_valid && bus.ui_ready) begin
            chk("lb phase", 32'(bus.uo_phase), nw % 2);
            if (nw / 2 < NO) begin
              for (int r = 0; r < NI; r++) begin
                if (nw % 2 == 0) ld[r*NO + int'(nw / 2)][1] = bus.uo_output[r];
                else             ld[r*NO + int'(nw / 2)][0] = bus.uo_output[r];
              end
            end
            nw++;
          end
          @(posedge clk); #1;
        end
      end
      bus.ui_ready = 1'b1;
      chk("lb done seen", 32'(fin), 1);
      chk("lb word count", nw, 8);
      for (int g = 0; g < 128; g++) begin
        logic [1:0] e;
        e = ((g / NO) <= 11 && (g % NO) <= 3) ? src[2*g +: 2] : 2'b00;
        chk($sformatf("lb w[%0d]", g), 32'(ld[g]), 32'(e));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
